// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
// The FSM state encoding, port identifiers and latency counter width live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Wide enough for MEM_LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-requester winner select.
// A sole requester always wins; ties go to port 0 or alternate against last_grant.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       any_valid,
    output logic       grant
);

    always_comb begin
        any_valid = |valid;
        grant     = PORT_CORE;
        if (valid == 2'b10) begin
            grant = PORT_DMA;
        end else if (valid == 2'b11) begin
            grant = FIXED_PRIO ? PORT_CORE : ~last_grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core (port 0) and DMA (port 1) onto a single fixed-latency memory.
// One transaction in flight at a time; the response returns to its owner MEM_LATENCY cycles after accept.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              owner_reg;
    logic              last_grant_reg;
    logic              rsp_we_reg;

    logic              any_valid;
    logic              win;
    logic              is_busy;
    logic              is_resp;
    logic              accept;
    logic [1:0]        ready_vec;
    logic [1:0]        rsp_vec;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    arb_pick2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .valid      ({p1_valid, p0_valid}),
        .last_grant (last_grant_reg),
        .any_valid  (any_valid),
        .grant      (win)
    );

    // Any encoding other than BUSY/RESP behaves as IDLE, so a corrupted state self-recovers.
    always_comb begin
        is_busy = (state_reg == S_BUSY);
        is_resp = (state_reg == S_RESP);
        accept  = !is_busy && !is_resp && any_valid;
    end

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (win == PORT_DMA) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi] = accept && (win == 1'(gi));
            assign rsp_vec[gi]   = is_resp && (owner_reg == 1'(gi));
        end
    endgenerate

    assign p0_ready     = ready_vec[0];
    assign p1_ready     = ready_vec[1];
    assign p0_rsp_valid = rsp_vec[0];
    assign p1_rsp_valid = rsp_vec[1];

    // Command is issued in the accept cycle itself; the bus is zero otherwise.
    assign mem_en    = accept;
    assign mem_we    = accept && sel_we;
    assign mem_addr  = accept ? sel_addr  : '0;
    assign mem_wdata = accept ? sel_wdata : '0;

    // Writes complete with a zero data word so the requester sees a clean ack.
    assign rsp_rdata = (is_resp && !rsp_we_reg) ? mem_rdata : '0;
    assign busy      = is_busy || is_resp;
    assign owner     = owner_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            owner_reg      <= PORT_CORE;
            last_grant_reg <= PORT_DMA;
            rsp_we_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    if (any_valid) begin
                        owner_reg      <= win;
                        last_grant_reg <= win;
                        rsp_we_reg     <= sel_we;
                        cnt_reg        <= CNT_W'(1);
                        state_reg      <= (MEM_LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single unified instruction/data memory between two requesters: the multi-cycle core (port 0) and a DMA/program-loader port (port 1).
- Accepts one transaction at a time and drives the memory command.
- Times the fixed memory read latency and returns the response to the owning requester.
- Sits between the core's memory interface (adrsrc-selected address, memwrite) and the memory macro, so the core FSM stalls on ready/rsp handshakes instead of assuming one-cycle memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal 1..15
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
p0_valid  input  1  core request valid
p0_we  input  1  core write enable
p0_addr  input  ADDR_W  core address
p0_wdata  input  DATA_W  core write data
p0_ready  output  1  core request accepted this cycle
p0_rsp_valid  output  1  core response (read data or write done)
p1_valid / p1_we / p1_addr / p1_wdata  input  1/1/ADDR_W/DATA_W  DMA request, same meaning as p0
p1_ready  output  1  DMA request accepted
p1_rsp_valid  output  1  DMA response
rsp_rdata  output  DATA_W  read data, valid with pX_rsp_valid
mem_en  output  1  memory command strobe
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  transaction outstanding
owner  output  1  port owning current or last transaction

Behaviour:
- Reset (rst asynchronous, active-high; clock clk):
  - state = S_IDLE, counter = 0, owner = 0, last_grant = 1 (port 0 wins the first tie).
  - All ready, rsp_valid, mem_en and mem_we = 0; mem_addr, mem_wdata and rsp_rdata = 0.
- Requester rule: pX_valid, pX_we, pX_addr and pX_wdata stay stable from assertion until the cycle pX_ready = 1. The arbiter never de-asserts ready once it has chosen a port within a cycle.
- S_IDLE:
  - If any valid is high, pick a winner: the sole requester; on a tie, port 0 when FIXED_PRIO = 1, otherwise the port != last_grant.
  - Same cycle T (combinational): pW_ready = 1, mem_en = 1, mem_we/addr/wdata = winner's payload.
  - Edge: owner <= W, last_grant <= W, counter <= 1.
  - Next state: S_RESP if MEM_LATENCY = 1, else S_BUSY.
- S_BUSY: mem_en = 0, busy = 1; counter increments; on counter == MEM_LATENCY-1 go to S_RESP.
- S_RESP (cycle T+MEM_LATENCY):
  - p<owner>_rsp_valid = 1 for exactly one cycle; the other port's rsp_valid stays 0.
  - rsp_rdata = mem_rdata (combinational) for reads, 0 for writes. Writes also get rsp_valid as a completion ack.
  - Next state S_IDLE; no accept in S_RESP.
- Timing:
  - Throughput is one transaction per MEM_LATENCY+1 cycles.
  - Accept-to-response latency is exactly MEM_LATENCY cycles.
- busy = 1 in S_BUSY and S_RESP.
- Requests arriving while not in S_IDLE see ready = 0 and wait; no queueing.
- Round-robin guarantees a waiting port is served at most one transaction after the current one.
- Simultaneous events:
  - A new request arriving in the same cycle as a response is not accepted until the following S_IDLE cycle.
  - A port may hold valid through its own response and is re-arbitrated normally.
- Reset mid-transaction: immediate return to S_IDLE; the in-flight response is dropped (no rsp_valid). The memory side may complete silently.
- Illegal state encoding: treated as S_IDLE.

Decomposition:
- Package mem_arb_pkg: state enum {S_IDLE, S_BUSY, S_RESP}, port id constants PORT_CORE = 0 and PORT_DMA = 1, counter width constant CNT_W = 4.
- One natural sub-module, arb_pick2: purely combinational two-input winner select from valid[1:0], last_grant and FIXED_PRIO.
- The FSM, counter and output muxing stay in the top module.

Test Plan:
- MEM_LATENCY = 2. p0 read of addr 0x10, memory returns 0xDEADBEEF → p0_ready at T, mem_en = 1/addr 0x10 at T, p0_rsp_valid with rsp_rdata = 0xDEADBEEF at T+2, idle at T+3.
- p1 write of 0x55 to 0x40 → mem_we = 1, mem_wdata = 0x55 at accept. p1_rsp_valid = 1 and rsp_rdata = 0 at T+MEM_LATENCY. p0_rsp_valid is never high.
- FIXED_PRIO = 0, both valid continuously for 4 transactions after reset → grant order 0,1,0,1, spaced MEM_LATENCY+1 cycles apart.
- FIXED_PRIO = 1, both valid continuously → p0 granted every time; p1_ready stays 0 until p0_valid drops, then p1 is granted at the next S_IDLE.
- MEM_LATENCY = 1 → accept at T, response at T+1, next accept at T+2; S_BUSY is never entered.
- MEM_LATENCY = 3, assert rst at T+1 after a p0 accept → all outputs 0 immediately. No p0_rsp_valid is emitted. After release, a new request is accepted with port 0 winning the tie.
